// File: rtl/gate_input_conditioner.sv
// gate_input_conditioner
//   Two-channel debouncer that feeds the two-input NAND gate block. Each channel takes a raw,
//   asynchronous level and passes it through a synchronizer chain. A stability counter and a
//   two-state FSM then accept a new level only after it has held for DEBOUNCE_CYCLES edges.
//   The channels are independent and share only clock and reset.
//
// Parameters:
//   SYNC_STAGES      flops per synchronizer chain (2..4)
//   DEBOUNCE_CYCLES  consecutive edges a new level must persist (2..65535)
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   raw_a  raw level, channel A
//   raw_b  raw level, channel B
//   a_out  debounced channel A (NAND input A)
//   b_out  debounced channel B (NAND input B)
//   busy   high while either channel is qualifying a candidate level
//   upd    (only with GATE_INPUT_CONDITIONER_EVENT_EN) one-cycle pulse after a_out/b_out change
//
// Optional feature macro: GATE_INPUT_CONDITIONER_EVENT_EN

module gate_input_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_a,
    input  logic raw_b,
    output logic a_out,
    output logic b_out,
    output logic busy
`ifdef GATE_INPUT_CONDITIONER_EVENT_EN
    ,
    output logic upd
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        StIdle,
        StCheck
    } state_e;

    logic [1:0] raw;
    logic [1:0] out;
    logic [1:0] next_check;  // channel will be in CHECK after this edge
    logic [1:0] flip;        // channel output changes on this edge

    assign raw = {raw_b, raw_a};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync;
        state_e                 state_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   out_q;

        assign sync = sync_q[SYNC_STAGES-1];
        assign out[c] = out_q;

        // These mirror the FSM transitions below; they feed the shared busy/upd flops.
        assign flip[c] = (state_q == StCheck) && (sync != out_q) && (cnt_q == CNT_LAST);
        assign next_check[c] = (sync != out_q) && !flip[c];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q  <= '0;
                state_q <= StIdle;
                cnt_q   <= '0;
                out_q   <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[c]};
                unique case (state_q)
                    StIdle: begin
                        if (sync != out_q) begin
                            state_q <= StCheck;
                            cnt_q   <= CNT_W'(1);
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    StCheck: begin
                        if (sync == out_q) begin
                            // Candidate bounced back before qualifying.
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            out_q   <= sync;
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign a_out = out[0];
    assign b_out = out[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= |next_check;
        end
    end

`ifdef GATE_INPUT_CONDITIONER_EVENT_EN
    // Single pulse even when both channels qualify on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd <= 1'b0;
        end else begin
            upd <= |flip;
        end
    end
`endif

endmodule

// File: tb/tb_gate_input_conditioner.sv
module tb_gate_input_conditioner;

    localparam int unsigned S = 2;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic raw_a, raw_b;
    logic a_out, b_out, busy;
`ifdef GATE_INPUT_CONDITIONER_EVENT_EN
    logic upd;
`endif

    int checks = 0;
    int errors = 0;

    gate_input_conditioner #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .raw_a(raw_a),
        .raw_b(raw_b),
        .a_out(a_out),
        .b_out(b_out),
        .busy (busy)
`ifdef GATE_INPUT_CONDITIONER_EVENT_EN
        ,
        .upd  (upd)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: raw sample history since reset, length of the current run of
    // synchronized samples that disagree with the output, and the outputs themselves.
    logic hist[2][$];
    int   run[2];
    logic m_out[2];
    logic m_busy;
    logic m_upd;

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            hist[c].delete();
            run[c]   = 0;
            m_out[c] = 1'b0;
        end
        m_busy = 1'b0;
        m_upd  = 1'b0;
    endfunction

    // One rising edge with reset released. The synchronized value seen at an edge is the raw
    // value sampled S edges earlier (0 if fewer than S samples exist since reset).
    function automatic void model_edge(input logic ra, input logic rb);
        logic r[2];
        logic s;
        r[0]   = ra;
        r[1]   = rb;
        m_upd  = 1'b0;
        m_busy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            s = (hist[c].size() >= S) ? hist[c][hist[c].size() - S] : 1'b0;
            hist[c].push_back(r[c]);
            if (hist[c].size() > S) void'(hist[c].pop_front());
            if (s != m_out[c]) begin
                run[c]++;
                if (run[c] == D) begin
                    m_out[c] = s;
                    run[c]   = 0;
                    m_upd    = 1'b1;
                end
            end else begin
                run[c] = 0;
            end
            if (run[c] > 0) m_busy = 1'b1;
        end
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".a_out"}, a_out, m_out[0]);
        check({tag, ".b_out"}, b_out, m_out[1]);
        check({tag, ".busy"}, busy, m_busy);
`ifdef GATE_INPUT_CONDITIONER_EVENT_EN
        check({tag, ".upd"}, upd, m_upd);
`endif
    endtask

    // Advance one clock edge, step the model, sample 1 ns later.
    task automatic tick(input string tag);
        logic ra, rb, rn;
        @(posedge clk);
        ra = raw_a;
        rb = raw_b;
        rn = rst_n;
        if (!rn) model_reset();
        else model_edge(ra, rb);
        #1;
        check_all(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        int hold_a, hold_b;
        rst_n = 1'b0;
        raw_a = 1'b0;
        raw_b = 1'b0;
        model_reset();
        #1;
        check_all("reset_async");
        ticks(3, "reset_held");
        rst_n = 1'b1;
        ticks(12, "idle_zero");

        // Single rise on A: exact latency S + D = 6.
        raw_a = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick("rise_a");
            if (e == 5) check("rise_a.edge5_low", a_out, 1'b0);
            if (e == 6) check("rise_a.edge6_high", a_out, 1'b1);
            if (e >= 3 && e <= 5) check("rise_a.busy_hi", busy, 1'b1);
            if (e == 6) check("rise_a.busy_lo", busy, 1'b0);
        end
        raw_a = 1'b0;
        ticks(10, "fall_a");

        // Three-cycle glitch on B is rejected.
        raw_b = 1'b1;
        ticks(3, "glitch_b");
        raw_b = 1'b0;
        ticks(8, "glitch_b_end");
        check("glitch_b.b_out", b_out, 1'b0);
        check("glitch_b.busy", busy, 1'b0);

        // Simultaneous rise on both channels.
        raw_a = 1'b1;
        raw_b = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick("both");
            if (e == 6) begin
                check("both.a_edge6", a_out, 1'b1);
                check("both.b_edge6", b_out, 1'b1);
            end
        end

        // Reset mid-qualification of a falling A.
        raw_a = 1'b0;
        ticks(3, "rst_mid");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_mid.a_async", a_out, 1'b0);
        check("rst_mid.busy_async", busy, 1'b0);
        check_all("rst_mid.async");
        tick("rst_mid.held");
        rst_n = 1'b1;
        ticks(10, "rst_mid.after");
        check("rst_mid.a_stays0", a_out, 1'b0);

        // A high, a 2-cycle dip rejected, then a final drop.
        raw_a = 1'b1;
        raw_b = 1'b0;
        ticks(8, "dip.setup");
        raw_a = 1'b0;
        ticks(2, "dip.low");
        raw_a = 1'b1;
        ticks(6, "dip.back");
        check("dip.rejected", a_out, 1'b1);
        raw_a = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick("drop");
            if (e == 5) check("drop.edge5", a_out, 1'b1);
            if (e == 6) check("drop.edge6", a_out, 1'b0);
        end

        // Randomized levels with random hold lengths and occasional resets.
        hold_a = 0;
        hold_b = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold_a == 0) begin
                raw_a  = 1'($urandom_range(0, 1));
                hold_a = $urandom_range(1, 8);
            end
            if (hold_b == 0) begin
                raw_b  = 1'($urandom_range(0, 1));
                hold_b = $urandom_range(1, 8);
            end
            hold_a--;
            hold_b--;
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all("rand.rst");
                tick("rand.rst_edge");
                rst_n = 1'b1;
            end else begin
                tick("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_input_conditioner.md
Name: gate_input_conditioner

Overview:
- Two-channel input conditioner that sits directly upstream of the two-input NAND gate block.
- Takes raw, asynchronous, bouncy switch/pushbutton levels and delivers clean, synchronized, debounced A/B levels for the gate.
- Each channel has a synchronizer chain, a stability counter and a two-state FSM.
- Channels are fully independent and share only clock and reset.

Parameters:
- SYNC_STAGES, 2, flip-flops in each synchronizer chain; legal range 2..4.
- DEBOUNCE_CYCLES, 16, consecutive clock edges a new level must persist before it is accepted; legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, width of each channel's stability counter (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is synchronous to clk.
- raw_a  input  1  raw asynchronous level for channel A.
- raw_b  input  1  raw asynchronous level for channel B.
- a_out  output  1  debounced level for channel A; drives the NAND gate input A.
- b_out  output  1  debounced level for channel B; drives the NAND gate input B.
- busy  output  1  high while either channel FSM is in CHECK.

Behaviour:
- Reset (rst_n=0): all sync flops, counters, a_out, b_out and busy = 0, and both FSMs = IDLE. This takes effect immediately, independent of clk.
- Reset mid-operation: any in-progress CHECK is abandoned. After release, a raw level of 1 is re-qualified from scratch with the full latency.
- Synchronizer: raw_x passes through SYNC_STAGES flops; the last flop is sync_x. Only sync_x feeds the FSM and counter.
- FSM states per channel: IDLE (output stable) and CHECK (candidate level being qualified).
- IDLE, sync_x == x_out: stay in IDLE; cnt = 0.
- IDLE, sync_x != x_out: go to CHECK; cnt = 1.
- CHECK, sync_x == x_out: bounce rejected; go to IDLE; cnt = 0; x_out unchanged.
- CHECK, sync_x != x_out and cnt == DEBOUNCE_CYCLES-1: x_out <= sync_x; go to IDLE; cnt = 0.
- CHECK, otherwise: cnt <= cnt + 1.
- Latency: raw level first sampled at edge 1 and held steady → x_out changes on edge SYNC_STAGES + DEBOUNCE_CYCLES. No earlier, no later.
- Glitch rejection: a pulse that is stable for fewer than DEBOUNCE_CYCLES synchronized cycles never reaches x_out.
- Counter never wraps: the maximum value reached is DEBOUNCE_CYCLES-1.
- Simultaneous changes on A and B are handled independently. If both qualify on the same edge, a_out and b_out update on that same edge with no ordering between them.
- busy = (fsm_a == CHECK) | (fsm_b == CHECK), registered so it is in step with the FSM state.
- Outputs are glitch-free: all are driven directly from flops.

Optional Feature:
- Macro: GATE_INPUT_CONDITIONER_EVENT_EN.
- Defined: adds output port upd (1 bit). upd is a one-cycle pulse, high in the cycle after any edge on which a_out or b_out changes value. It is a single pulse even when both outputs change together. It resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset held, then released with raw_a = raw_b = 0 → a_out = b_out = 0 and busy = 0 indefinitely.
- raw_a 0→1 before edge 1, held high → a_out rises exactly at edge 6. busy is high after edges 3–5 and low after edge 6. b_out stays 0.
- raw_b pulses high for 3 cycles, then returns to 0 → b_out never changes. The FSM returns to IDLE and busy drops.
- raw_a and raw_b both 0→1 before the same edge → a_out and b_out both rise at edge 6. With the macro defined, upd is high for exactly 1 cycle afterwards.
- a_out = 1, raw_a 1→0, rst_n pulsed low at edge 4 for one cycle → a_out = 0 immediately and busy = 0. With raw_a held at 0 after release, a_out stays 0.
- a_out = 1, raw_a drops for 2 cycles, returns to 1, then drops and stays 0 → the first dip is rejected. a_out falls 6 edges after the final drop.
